// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational ALU between
// NUM_REQ requesters, with a one-entry registered response slot.
// A drain of the held result and the issue of a new op can happen in the same
// cycle, so a requester that drains every cycle gets one op per clock.
// Optional feature macro: ALU_ARB_LOCK_EN adds req_lock, which makes an
// accepted requester keep priority for its next op.
module alu_share_arb #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*3-1:0]     req_fn,
    input  logic [NUM_REQ*7-1:0]     req_funct7,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       req_lock,
`endif
    output logic [2:0]               alu_fn,
    output logic [6:0]               alu_funct7,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    input  logic [WIDTH-1:0]         alu_out,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_data
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [PW:0]   NREQ = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_p1;
    logic [PW-1:0]    owner_p1;
    logic [PW-1:0]    ptr_p1;
    logic [WIDTH-1:0] data_p1;

    logic [PW:0]      scan_idx;
    logic [PW-1:0]    grant;
    logic             any_valid;
    logic             drain;
    logic             issue_ok;
    logic [PW-1:0]    ptr_nxt;

    // Round-robin scan from ptr upward with wrap; lowest offset wins.
    always_comb begin
        grant     = ptr_p1;
        any_valid = 1'b0;
        scan_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr_p1} + (PW+1)'(k);
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (req_valid[scan_idx[PW-1:0]]) begin
                grant     = scan_idx[PW-1:0];
                any_valid = 1'b1;
            end
        end
    end

    // Issue permission: slot free, or the owner drains it this very cycle.
    always_comb begin
        drain     = (state_p1 == FULL) && rsp_ready[owner_p1];
        issue_ok  = rst_n && any_valid && ((state_p1 == EMPTY) || drain);
        req_ready = '0;
        req_ready[grant] = issue_ok;
        rsp_valid = '0;
        rsp_valid[owner_p1] = (state_p1 == FULL);
    end

    // ALU operand mux follows the grant (ptr's requester when nothing is pending).
    always_comb begin
        alu_fn     = req_fn[int'(grant)*3 +: 3];
        alu_funct7 = req_funct7[int'(grant)*7 +: 7];
        alu_a      = req_a[int'(grant)*WIDTH +: WIDTH];
        alu_b      = req_b[int'(grant)*WIDTH +: WIDTH];
    end

    // Next round-robin pointer on accept; a locked requester keeps priority.
    always_comb begin
        ptr_nxt = (grant == LAST) ? '0 : grant + PW'(1);
`ifdef ALU_ARB_LOCK_EN
        if (req_lock[grant]) begin
            ptr_nxt = grant;
        end
`endif
    end

    // Response slot and arbitration state; accept wins over a plain drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= EMPTY;
            owner_p1 <= '0;
            ptr_p1   <= '0;
            data_p1  <= '0;
        end else if (issue_ok) begin
            state_p1 <= FULL;
            owner_p1 <= grant;
            ptr_p1   <= ptr_nxt;
            data_p1  <= alu_out;
        end else if (drain) begin
            state_p1 <= EMPTY;
        end
    end

    assign rsp_data = data_p1;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed vector table plus hand-written sequences for the
// shared-ALU arbiter (2-requester and 3-requester instances).
module tb_alu_share_arb;

    localparam int W = 32;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_n;

    // 2-requester instance
    logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2:0]   fn0, fn1;
    logic [6:0]   f70, f71;
    logic [W-1:0] a0, b0, a1, b1;
    logic [2:0]   alu_fn;
    logic [6:0]   alu_funct7;
    logic [W-1:0] alu_a, alu_b, alu_out, rsp_data;
`ifdef ALU_ARB_LOCK_EN
    logic [1:0]   req_lock;
`endif

    // 3-requester instance
    logic [2:0]     v3, rr3, rv3, rrdy3;
    logic [8:0]     fn3;
    logic [20:0]    f73;
    logic [3*W-1:0] a3, b3;
    logic [2:0]     alu3_fn;
    logic [6:0]     alu3_f7;
    logic [W-1:0]   alu3_a, alu3_b, alu3_out, data3;
`ifdef ALU_ARB_LOCK_EN
    logic [2:0]     lock3;
`endif

    int checks = 0;
    int failures = 0;

    // Reference ALU (RISC-V funct3 style encoding)
    function automatic logic [W-1:0] alu_model(input logic [2:0] fn, input logic [6:0] f7,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        case (fn)
            3'd0: return f7[5] ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_out  = alu_model(alu_fn, alu_funct7, alu_a, alu_b);
    assign alu3_out = alu_model(alu3_fn, alu3_f7, alu3_a, alu3_b);

    alu_share_arb #(.WIDTH(W), .NUM_REQ(2)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fn     ({fn1, fn0}),
        .req_funct7 ({f71, f70}),
        .req_a      ({a1, a0}),
        .req_b      ({b1, b0}),
`ifdef ALU_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .alu_fn     (alu_fn),
        .alu_funct7 (alu_funct7),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data)
    );

    alu_share_arb #(.WIDTH(W), .NUM_REQ(3)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (v3),
        .req_ready  (rr3),
        .req_fn     (fn3),
        .req_funct7 (f73),
        .req_a      (a3),
        .req_b      (b3),
`ifdef ALU_ARB_LOCK_EN
        .req_lock   (lock3),
`endif
        .alu_fn     (alu3_fn),
        .alu_funct7 (alu3_f7),
        .alu_a      (alu3_a),
        .alu_b      (alu3_b),
        .alu_out    (alu3_out),
        .rsp_valid  (rv3),
        .rsp_ready  (rrdy3),
        .rsp_data   (data3)
    );

    typedef struct {
        bit           pre_rst;
        logic [1:0]   valid;
        logic [2:0]   fa;
        logic [6:0]   f7a;
        logic [W-1:0] aa, ba;
        logic [2:0]   fb;
        logic [6:0]   f7b;
        logic [W-1:0] ab, bb;
        logic [1:0]   rrdy;
        logic [1:0]   exp_rr;
        logic [1:0]   exp_rv;
        bit           chk_data;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit pr, input logic [1:0] v,
                                input logic [2:0] fa, input logic [6:0] f7a,
                                input logic [W-1:0] aa, input logic [W-1:0] ba,
                                input logic [2:0] fb, input logic [6:0] f7b,
                                input logic [W-1:0] ab, input logic [W-1:0] bb,
                                input logic [1:0] rrdy, input logic [1:0] er,
                                input logic [1:0] ev, input bit cd, input logic [W-1:0] ed);
        vec_t t;
        t.pre_rst = pr; t.valid = v;
        t.fa = fa; t.f7a = f7a; t.aa = aa; t.ba = ba;
        t.fb = fb; t.f7b = f7b; t.ab = ab; t.bb = bb;
        t.rrdy = rrdy; t.exp_rr = er; t.exp_rv = ev;
        t.chk_data = cd; t.exp_data = ed;
        return t;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        v3 = '0;
        rrdy3 = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b01; rsp_ready = '0;
        fn0 = '0; fn1 = '0; f70 = '0; f71 = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        v3 = 3'b001; rrdy3 = '0; fn3 = '0; f73 = '0; a3 = '0; b3 = '0;
`ifdef ALU_ARB_LOCK_EN
        req_lock = '0; lock3 = '0;
`endif

        // Test 1: single request, hold, drain
        vecs.push_back(mk(0, 2'b01, 3'd0, 7'd0, 32'd5, 32'd3, 3'd0, 7'd0, 32'd0, 32'd0, 2'b00, 2'b01, 2'b00, 1, 32'd0));
        vecs.push_back(mk(0, 2'b00, 3'd0, 7'd0, 32'd5, 32'd3, 3'd0, 7'd0, 32'd0, 32'd0, 2'b00, 2'b00, 2'b01, 1, 32'd8));
        vecs.push_back(mk(0, 2'b00, 3'd0, 7'd0, 32'd5, 32'd3, 3'd0, 7'd0, 32'd0, 32'd0, 2'b00, 2'b00, 2'b01, 1, 32'd8));
        vecs.push_back(mk(0, 2'b00, 3'd0, 7'd0, 32'd5, 32'd3, 3'd0, 7'd0, 32'd0, 32'd0, 2'b01, 2'b00, 2'b01, 1, 32'd8));
        vecs.push_back(mk(0, 2'b00, 3'd0, 7'd0, 32'd5, 32'd3, 3'd0, 7'd0, 32'd0, 32'd0, 2'b00, 2'b00, 2'b00, 0, 32'd0));
        // Test 2: contention, 10-4 SUB vs 6 AND 3, always draining
        vecs.push_back(mk(1, 2'b11, 3'd0, 7'h20, 32'd10, 32'd4, 3'd7, 7'd0, 32'd6, 32'd3, 2'b11, 2'b01, 2'b00, 1, 32'd0));
        vecs.push_back(mk(0, 2'b11, 3'd0, 7'h20, 32'd10, 32'd4, 3'd7, 7'd0, 32'd6, 32'd3, 2'b11, 2'b10, 2'b01, 1, 32'd6));
        vecs.push_back(mk(0, 2'b11, 3'd0, 7'h20, 32'd10, 32'd4, 3'd7, 7'd0, 32'd6, 32'd3, 2'b11, 2'b01, 2'b10, 1, 32'd2));
        vecs.push_back(mk(0, 2'b11, 3'd0, 7'h20, 32'd10, 32'd4, 3'd7, 7'd0, 32'd6, 32'd3, 2'b11, 2'b10, 2'b01, 1, 32'd6));
        vecs.push_back(mk(0, 2'b00, 3'd0, 7'h20, 32'd10, 32'd4, 3'd7, 7'd0, 32'd6, 32'd3, 2'b11, 2'b00, 2'b10, 1, 32'd2));
        vecs.push_back(mk(0, 2'b00, 3'd0, 7'h20, 32'd10, 32'd4, 3'd7, 7'd0, 32'd6, 32'd3, 2'b11, 2'b00, 2'b00, 0, 32'd0));
        // Test 3: backpressure on 0xFF while requester 1 waits
        vecs.push_back(mk(0, 2'b01, 3'd6, 7'd0, 32'hF0, 32'h0F, 3'd0, 7'd0, 32'd1, 32'd2, 2'b00, 2'b01, 2'b00, 0, 32'd0));
        vecs.push_back(mk(0, 2'b10, 3'd6, 7'd0, 32'hF0, 32'h0F, 3'd0, 7'd0, 32'd1, 32'd2, 2'b10, 2'b00, 2'b01, 1, 32'hFF));
        vecs.push_back(mk(0, 2'b10, 3'd6, 7'd0, 32'hF0, 32'h0F, 3'd0, 7'd0, 32'd1, 32'd2, 2'b10, 2'b00, 2'b01, 1, 32'hFF));
        vecs.push_back(mk(0, 2'b10, 3'd6, 7'd0, 32'hF0, 32'h0F, 3'd0, 7'd0, 32'd1, 32'd2, 2'b00, 2'b00, 2'b01, 1, 32'hFF));
        vecs.push_back(mk(0, 2'b10, 3'd6, 7'd0, 32'hF0, 32'h0F, 3'd0, 7'd0, 32'd1, 32'd2, 2'b01, 2'b10, 2'b01, 1, 32'hFF));
        vecs.push_back(mk(0, 2'b00, 3'd6, 7'd0, 32'hF0, 32'h0F, 3'd0, 7'd0, 32'd1, 32'd2, 2'b10, 2'b00, 2'b10, 1, 32'd3));
        vecs.push_back(mk(0, 2'b00, 3'd6, 7'd0, 32'hF0, 32'h0F, 3'd0, 7'd0, 32'd1, 32'd2, 2'b00, 2'b00, 2'b00, 0, 32'd0));

        // Reset state, with a request pending while reset is held
        repeat (2) @(negedge clk);
        #2;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        chk("reset req_ready n3", 32'(rr3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        v3 = '0;

        foreach (vecs[i]) begin
            if (vecs[i].pre_rst) do_reset();
            @(negedge clk);
            req_valid = vecs[i].valid;
            fn0 = vecs[i].fa; f70 = vecs[i].f7a; a0 = vecs[i].aa; b0 = vecs[i].ba;
            fn1 = vecs[i].fb; f71 = vecs[i].f7b; a1 = vecs[i].ab; b1 = vecs[i].bb;
            rsp_ready = vecs[i].rrdy;
            #2;
            chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].exp_rr));
            chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_rv));
            if (vecs[i].chk_data)
                chk($sformatf("vec%0d rsp_data", i), rsp_data, vecs[i].exp_data);
        end

        // Wrap on the 3-requester instance: move ptr to 2, then 0 and 1 compete
        do_reset();
        @(negedge clk);
        a3[W-1:0] = 32'd7;  b3[W-1:0] = 32'd0;
        a3[2*W-1:W] = 32'd1; b3[2*W-1:W] = 32'd1;
        v3 = 3'b010; rrdy3 = 3'b111;
        #2 chk("wrap first grant", 32'(rr3), 32'b010);
        @(negedge clk);
        v3 = 3'b000;
        #2;
        chk("wrap rsp_valid r1", 32'(rv3), 32'b010);
        chk("wrap rsp_data r1", data3, 32'd2);
        @(negedge clk);
        v3 = 3'b011;
        #2 chk("wrap grant 0", 32'(rr3), 32'b001);
        @(negedge clk);
        v3 = 3'b010;
        #2;
        chk("wrap grant 1", 32'(rr3), 32'b010);
        chk("wrap rsp_valid r0", 32'(rv3), 32'b001);
        chk("wrap rsp_data r0", data3, 32'd7);
        @(negedge clk);
        v3 = 3'b000;
        #2;
        chk("wrap rsp_valid r1b", 32'(rv3), 32'b010);
        chk("wrap rsp_data r1b", data3, 32'd2);

        // Async reset while FULL, ptr pointing at requester 1
        do_reset();
        @(negedge clk);
        req_valid = 2'b01; fn0 = 3'd0; f70 = 7'd0; a0 = 32'd5; b0 = 32'd3;
        fn1 = 3'd0; f71 = 7'd0; a1 = 32'h55; b1 = 32'd0; rsp_ready = 2'b00;
        @(negedge clk);
        req_valid = 2'b00;
        #2;
        chk("async pre rsp_valid", 32'(rsp_valid), 32'b01);
        chk("idle alu_a follows ptr", alu_a, 32'h55);
        #4 rst_n = 1'b0;
        #1;
        chk("async rsp_valid drop", 32'(rsp_valid), 32'd0);
        chk("async rsp_data clear", rsp_data, 32'd0);
        req_valid = 2'b11;
        #1 chk("async req_ready low", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2 chk("after reset grant 0", 32'(req_ready), 32'b01);

`ifdef ALU_ARB_LOCK_EN
        // Lock: requester 1 keeps priority for two locked accepts
        do_reset();
        @(negedge clk);
        req_valid = 2'b11; rsp_ready = 2'b11; req_lock = 2'b10;
        a0 = 32'd1; b0 = 32'd1; a1 = 32'd2; b1 = 32'd2;
        #2 chk("lock grant 0 first", 32'(req_ready), 32'b01);
        @(negedge clk);
        #2 chk("lock grant 1 a", 32'(req_ready), 32'b10);
        @(negedge clk);
        #2 chk("lock grant 1 b", 32'(req_ready), 32'b10);
        @(negedge clk);
        req_lock = 2'b00;
        #2 chk("unlock grant 1", 32'(req_ready), 32'b10);
        @(negedge clk);
        #2 chk("unlock grant 0", 32'(req_ready), 32'b01);
`endif

        @(negedge clk);
        req_valid = '0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
